// File: rtl/pwm_regs_pkg.sv
// Register map constants, control/status bit positions and the byte-lane merge
// helper shared by the multi-channel PWM top level and its channel slices.
package pwm_regs_pkg;

    localparam int ADDR_PERIOD = 0;
    localparam int ADDR_CTRL   = 1;
    localparam int ADDR_CH_EN  = 2;
    localparam int ADDR_INVERT = 3;
    localparam int ADDR_STATUS = 4;
    localparam int ADDR_DUTY0  = 5;

    localparam int CTRL_RUN_BIT          = 0;
    localparam int CTRL_IRQ_EN_BIT       = 1;
    localparam int STATUS_PERIOD_END_BIT = 0;

    // Replace only the byte lanes flagged in be; the caller truncates to the register width.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow/active pair, compare against the shared counter,
// and the registered (optionally inverted) output.
module pwm_channel
    import pwm_regs_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int DUTY_RST = 250000
)(
    input  logic             csi_clk,
    input  logic             rsi_rst_n,
    input  logic             duty_wr,
    input  logic [3:0]       byteenable,
    input  logic [31:0]      writedata,
    input  logic             load,
    input  logic             run,
    input  logic             enable,
    input  logic             invert,
    input  logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] duty_shadow,
    output logic             pwm_out
);

    logic [CNT_W-1:0] duty_active;
    logic             raw;

    assign raw = run & enable & (count < duty_active);

    // The active copy samples the pre-write shadow, so a write on the load cycle waits one period.
    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            duty_shadow <= CNT_W'(DUTY_RST);
            duty_active <= CNT_W'(DUTY_RST);
            pwm_out     <= 1'b0;
        end else begin
            if (duty_wr) begin
                duty_shadow <= CNT_W'(merge_bytes(32'(duty_shadow), writedata, byteenable));
            end
            if (load) begin
                duty_active <= duty_shadow;
            end
            pwm_out <= raw ^ invert;
        end
    end

endmodule

// File: rtl/pwm_multi_avalon.sv
// Multi-channel PWM with an Avalon-MM slave: shared period counter, control and
// status registers, period-end interrupt, and NUM_CH pwm_channel slices.
module pwm_multi_avalon
    import pwm_regs_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int CNT_W      = 32,
    parameter  int PERIOD_RST = 500000,
    parameter  int DUTY_RST   = 250000,
    localparam int ADDR_W     = $clog2(5 + NUM_CH)
)(
    input  logic              csi_clk,
    input  logic              rsi_rst_n,
    input  logic              avs_s0_chip_select,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic [3:0]        avs_s0_byteenable,
    input  logic [31:0]       avs_s0_writedata,
    output logic [31:0]       avs_s0_readdata,
    output logic [NUM_CH-1:0] coe_pwm_out,
    output logic              ins_irq0_irq
);

    logic              wr_access;
    logic              rd_access;
    logic              sel_period;
    logic              sel_ctrl;
    logic              sel_ch_en;
    logic              sel_invert;
    logic              sel_status;
    logic [NUM_CH-1:0] duty_wr;

    logic [CNT_W-1:0]  period_shadow;
    logic [CNT_W-1:0]  period_active;
    logic [CNT_W-1:0]  count;
    logic              ctrl_run;
    logic              ctrl_irq_en;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] invert;
    logic              period_end;

    logic              counting;
    logic              wrap;
    logic              load;
    logic [31:0]       rd_mux;
    logic [CNT_W-1:0]  duty_shadow [NUM_CH];

    assign wr_access  = avs_s0_chip_select & avs_s0_write;
    assign rd_access  = avs_s0_chip_select & avs_s0_read;
    assign sel_period = wr_access && (avs_s0_address == ADDR_W'(ADDR_PERIOD));
    assign sel_ctrl   = wr_access && (avs_s0_address == ADDR_W'(ADDR_CTRL));
    assign sel_ch_en  = wr_access && (avs_s0_address == ADDR_W'(ADDR_CH_EN));
    assign sel_invert = wr_access && (avs_s0_address == ADDR_W'(ADDR_INVERT));
    assign sel_status = wr_access && (avs_s0_address == ADDR_W'(ADDR_STATUS));

    // An idle counter (stopped or zero period) keeps the active copies tracking the
    // shadows, so a running block with period 0 still picks up a new period.
    assign counting = ctrl_run && (period_active != '0);
    assign wrap     = counting && (count == period_active - CNT_W'(1));
    assign load     = !counting || wrap;

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            period_shadow <= CNT_W'(PERIOD_RST);
            period_active <= CNT_W'(PERIOD_RST);
            count         <= '0;
        end else begin
            if (sel_period) begin
                period_shadow <= CNT_W'(merge_bytes(32'(period_shadow), avs_s0_writedata,
                                                    avs_s0_byteenable));
            end
            if (load) begin
                period_active <= period_shadow;
            end
            if (!counting || wrap) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // A wrap setting period_end takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            ctrl_run     <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            ch_en        <= '0;
            invert       <= '0;
            period_end   <= 1'b0;
            ins_irq0_irq <= 1'b0;
        end else begin
            if (sel_ctrl && avs_s0_byteenable[0]) begin
                ctrl_run    <= avs_s0_writedata[CTRL_RUN_BIT];
                ctrl_irq_en <= avs_s0_writedata[CTRL_IRQ_EN_BIT];
            end
            if (sel_ch_en) begin
                ch_en <= NUM_CH'(merge_bytes(32'(ch_en), avs_s0_writedata, avs_s0_byteenable));
            end
            if (sel_invert) begin
                invert <= NUM_CH'(merge_bytes(32'(invert), avs_s0_writedata, avs_s0_byteenable));
            end
            if (wrap) begin
                period_end <= 1'b1;
            end else if (sel_status && avs_s0_byteenable[0]
                         && avs_s0_writedata[STATUS_PERIOD_END_BIT]) begin
                period_end <= 1'b0;
            end
            ins_irq0_irq <= period_end & ctrl_irq_en;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (avs_s0_address == ADDR_W'(ADDR_PERIOD)) begin
            rd_mux = 32'(period_shadow);
        end else if (avs_s0_address == ADDR_W'(ADDR_CTRL)) begin
            rd_mux[CTRL_RUN_BIT]    = ctrl_run;
            rd_mux[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
        end else if (avs_s0_address == ADDR_W'(ADDR_CH_EN)) begin
            rd_mux = 32'(ch_en);
        end else if (avs_s0_address == ADDR_W'(ADDR_INVERT)) begin
            rd_mux = 32'(invert);
        end else if (avs_s0_address == ADDR_W'(ADDR_STATUS)) begin
            rd_mux[STATUS_PERIOD_END_BIT] = period_end;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs_s0_address == ADDR_W'(ADDR_DUTY0 + i)) begin
                rd_mux = 32'(duty_shadow[i]);
            end
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            avs_s0_readdata <= '0;
        end else begin
            avs_s0_readdata <= rd_access ? rd_mux : 32'h0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign duty_wr[i] = wr_access && (avs_s0_address == ADDR_W'(ADDR_DUTY0 + i));

        pwm_channel #(
            .CNT_W    (CNT_W),
            .DUTY_RST (DUTY_RST)
        ) u_channel (
            .csi_clk     (csi_clk),
            .rsi_rst_n   (rsi_rst_n),
            .duty_wr     (duty_wr[i]),
            .byteenable  (avs_s0_byteenable),
            .writedata   (avs_s0_writedata),
            .load        (load),
            .run         (ctrl_run),
            .enable      (ch_en[i]),
            .invert      (invert[i]),
            .count       (count),
            .duty_shadow (duty_shadow[i]),
            .pwm_out     (coe_pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_avalon.sv
// Self-checking bench for pwm_multi_avalon: register access, PWM waveforms,
// shadow/active duty updates, period-end interrupt and asynchronous reset.
module tb_pwm_multi_avalon;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = $clog2(5 + NUM_CH);

    logic              csi_clk = 1'b0;
    logic              rsi_rst_n = 1'b0;
    logic              avs_s0_chip_select = 1'b0;
    logic              avs_s0_read = 1'b0;
    logic              avs_s0_write = 1'b0;
    logic [ADDR_W-1:0] avs_s0_address = '0;
    logic [3:0]        avs_s0_byteenable = '0;
    logic [31:0]       avs_s0_writedata = '0;
    logic [31:0]       avs_s0_readdata;
    logic [NUM_CH-1:0] coe_pwm_out;
    logic              ins_irq0_irq;

    int checks = 0;
    int errors = 0;

    pwm_multi_avalon dut (
        .csi_clk            (csi_clk),
        .rsi_rst_n          (rsi_rst_n),
        .avs_s0_chip_select (avs_s0_chip_select),
        .avs_s0_read        (avs_s0_read),
        .avs_s0_write       (avs_s0_write),
        .avs_s0_address     (avs_s0_address),
        .avs_s0_byteenable  (avs_s0_byteenable),
        .avs_s0_writedata   (avs_s0_writedata),
        .avs_s0_readdata    (avs_s0_readdata),
        .coe_pwm_out        (coe_pwm_out),
        .ins_irq0_irq       (ins_irq0_irq)
    );

    always #5 csi_clk = ~csi_clk;

    // One bus cycle starting just after a falling edge; returns at the next falling edge.
    task automatic bus_cycle(input logic do_wr, input logic do_rd, input int addr,
                             input logic [31:0] data, input logic [3:0] be);
        avs_s0_chip_select = do_wr | do_rd;
        avs_s0_write       = do_wr;
        avs_s0_read        = do_rd;
        avs_s0_address     = ADDR_W'(addr);
        avs_s0_writedata   = data;
        avs_s0_byteenable  = be;
        @(negedge csi_clk);
        avs_s0_chip_select = 1'b0;
        avs_s0_write       = 1'b0;
        avs_s0_read        = 1'b0;
    endtask

    task automatic idle();
        bus_cycle(1'b0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    task automatic bus_write(input int addr, input logic [31:0] data);
        bus_cycle(1'b1, 1'b0, addr, data, 4'hF);
    endtask

    task automatic bus_read(input int addr, output logic [31:0] data);
        bus_cycle(1'b0, 1'b1, addr, 32'h0, 4'h0);
        data = avs_s0_readdata;
    endtask

    // Reference: in a period, output i is high for the first duty[i] counts, then low.
    function automatic logic [NUM_CH-1:0] model_out(input int phase, input int duty [NUM_CH],
                                                    input logic [NUM_CH-1:0] en,
                                                    input logic [NUM_CH-1:0] inv,
                                                    input bit run);
        logic [NUM_CH-1:0] result;
        for (int i = 0; i < NUM_CH; i++) begin
            result[i] = (run && en[i] && (phase < duty[i])) ^ inv[i];
        end
        return result;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0] be);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return result;
    endfunction

    task automatic configure(input int period, input int duty [NUM_CH],
                             input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] inv);
        bus_write(0, 32'(period));
        for (int i = 0; i < NUM_CH; i++) begin
            bus_write(5 + i, 32'(duty[i]));
        end
        bus_write(2, 32'(en));
        bus_write(3, 32'(inv));
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int addrs [6] = '{0, 5, 8, 1, 4, 12};
        logic [31:0] exp_vals [6] = '{32'd500000, 32'd250000, 32'd250000, 32'd0, 32'd0, 32'd0};
        rsi_rst_n = 1'b0;
        repeat (2) @(negedge csi_clk);
        checks++;
        if (coe_pwm_out !== 4'h0 || ins_irq0_irq !== 1'b0 || avs_s0_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got pwm=%h irq=%b rd=%h required 0/0/0",
                     coe_pwm_out, ins_irq0_irq, avs_s0_readdata);
        end
        rsi_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], d);
            checks++;
            if (d !== exp_vals[i]) begin
                errors++;
                $display("FAIL reset_read_addr%0d: got %0d required %0d", addrs[i], d, exp_vals[i]);
            end
        end
        checks++;
        if (coe_pwm_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_pwm_idle: got %h required 0", coe_pwm_out);
        end
    endtask

    task automatic test_basic_pwm();
        int duty [NUM_CH] = '{3, 0, 0, 0};
        logic [NUM_CH-1:0] exp;
        configure(10, duty, 4'b0001, 4'b0000);
        bus_write(1, 32'h1);
        for (int k = 1; k <= 30; k++) begin
            idle();
            exp = model_out((k - 1) % 10, duty, 4'b0001, 4'b0000, 1'b1);
            checks++;
            if (coe_pwm_out !== exp) begin
                errors++;
                $display("FAIL basic_pwm k=%0d: got %b required %b", k, coe_pwm_out, exp);
            end
        end
        bus_write(1, 32'h0);
    endtask

    task automatic test_random_patterns();
        int duty [NUM_CH];
        int period;
        logic [NUM_CH-1:0] en, inv, exp;
        for (int it = 0; it < 4; it++) begin
            period = $urandom_range(3, 12);
            for (int i = 0; i < NUM_CH; i++) duty[i] = $urandom_range(0, period + 3);
            en  = NUM_CH'($urandom_range(0, 15));
            inv = NUM_CH'($urandom_range(0, 15));
            if (it == 0) begin
                period = 10;
                duty   = '{0, 0, 12, 4};
                en     = 4'b0110;
                inv    = 4'b0100;
            end
            configure(period, duty, en, inv);
            checks++;
            if (coe_pwm_out !== inv) begin
                errors++;
                $display("FAIL stopped_level it=%0d: got %b required %b", it, coe_pwm_out, inv);
            end
            bus_write(1, 32'h1);
            for (int k = 1; k <= 3 * period; k++) begin
                idle();
                exp = model_out((k - 1) % period, duty, en, inv, 1'b1);
                checks++;
                if (coe_pwm_out !== exp) begin
                    errors++;
                    $display("FAIL pattern it=%0d P=%0d k=%0d: got %b required %b",
                             it, period, k, coe_pwm_out, exp);
                end
            end
            bus_write(1, 32'h0);
        end
    endtask

    // Duty for period n is the last value written strictly before that period's first edge.
    task automatic test_duty_update();
        int duty [NUM_CH];
        int period, n, d;
        int wedge [3];
        int wval [3];
        bit hit;
        logic [NUM_CH-1:0] exp;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                period = 10;
                duty   = '{3, 0, 0, 0};
                wedge  = '{5, 20, 33};
                wval   = '{8, 5, 0};
            end else begin
                period = $urandom_range(6, 12);
                duty   = '{$urandom_range(0, period), 0, 0, 0};
                wedge  = '{$urandom_range(1, period - 1), 2 * period,
                           3 * period + $urandom_range(1, period - 1)};
                for (int j = 0; j < 3; j++) wval[j] = $urandom_range(0, period + 1);
            end
            configure(period, duty, 4'b0001, 4'b0000);
            bus_write(1, 32'h1);
            for (int k = 1; k <= 5 * period; k++) begin
                hit = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    if (wedge[j] == k) begin
                        bus_write(5, 32'(wval[j]));
                        hit = 1'b1;
                    end
                end
                if (!hit) idle();
                n = (k - 1) / period;
                d = duty[0];
                for (int j = 0; j < 3; j++) begin
                    if (wedge[j] < n * period) d = wval[j];
                end
                exp = {3'b000, ((k - 1) % period) < d};
                checks++;
                if (coe_pwm_out !== exp) begin
                    errors++;
                    $display("FAIL duty_update it=%0d k=%0d: got %b required %b",
                             it, k, coe_pwm_out, exp);
                end
            end
            bus_write(1, 32'h0);
        end
    endtask

    // Status model: set on every wrap edge, cleared by W1C only on non-wrap edges.
    task automatic test_irq();
        int duty [NUM_CH] = '{1, 0, 0, 0};
        logic [31:0] d;
        bit st, exp_prev;
        configure(4, duty, 4'b0000, 4'b0000);
        bus_write(4, 32'h1);
        bus_write(1, 32'h3);
        st = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            exp_prev = st;
            if (k == 8 || k == 10) begin
                bus_write(4, 32'h1);
            end else if (k == 9 || k == 11) begin
                bus_read(4, d);
                checks++;
                if (d !== {31'h0, exp_prev}) begin
                    errors++;
                    $display("FAIL status_read k=%0d: got %h required %h", k, d, {31'h0, exp_prev});
                end
            end else begin
                idle();
            end
            if (k % 4 == 0) st = 1'b1;
            else if (k == 8 || k == 10) st = 1'b0;
            checks++;
            if (ins_irq0_irq !== exp_prev) begin
                errors++;
                $display("FAIL irq k=%0d: got %b required %b", k, ins_irq0_irq, exp_prev);
            end
        end
        bus_write(1, 32'h0);
        bus_write(4, 32'h1);
    endtask

    task automatic test_byteenable();
        logic [31:0] d, old_val, wdata, exp;
        logic [3:0] be;
        int addr;
        bus_write(0, 32'h0007_A120);
        bus_cycle(1'b1, 1'b0, 0, 32'hAABB_CCDD, 4'b0010);
        bus_read(0, d);
        checks++;
        if (d !== 32'h0007_CC20) begin
            errors++;
            $display("FAIL period_byte1: got %h required %h", d, 32'h0007_CC20);
        end
        for (int it = 0; it < 6; it++) begin
            addr    = 5 + $urandom_range(0, NUM_CH - 1);
            old_val = $urandom;
            wdata   = $urandom;
            be      = 4'($urandom_range(0, 15));
            bus_write(addr, old_val);
            bus_cycle(1'b1, 1'b0, addr, wdata, be);
            bus_read(addr, d);
            exp = model_merge(old_val, wdata, be);
            checks++;
            if (d !== exp) begin
                errors++;
                $display("FAIL duty_be addr=%0d be=%b: got %h required %h", addr, be, d, exp);
            end
        end
        bus_write(2, 32'hFFFF_FFFF);
        bus_read(2, d);
        checks++;
        if (d !== 32'h0000_000F) begin
            errors++;
            $display("FAIL ch_en_mask: got %h required %h", d, 32'h0000_000F);
        end
        bus_write(1, 32'hFFFF_FFFF);
        bus_read(1, d);
        checks++;
        if (d !== 32'h0000_0003) begin
            errors++;
            $display("FAIL ctrl_mask: got %h required %h", d, 32'h0000_0003);
        end
        bus_write(1, 32'h0);
        bus_write(2, 32'h0);
        bus_write(13, 32'h1234_5678);
        bus_read(13, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: got %h required 0", d);
        end
    endtask

    task automatic test_reset_midrun();
        int duty [NUM_CH] = '{10, 5, 0, 12};
        logic [31:0] d;
        logic [NUM_CH-1:0] exp;
        configure(10, duty, 4'b1111, 4'b0000);
        bus_write(4, 32'h1);
        bus_write(1, 32'h3);
        repeat (15) idle();
        exp = model_out(14 % 10, duty, 4'b1111, 4'b0000, 1'b1);
        checks++;
        if (coe_pwm_out !== exp || ins_irq0_irq !== 1'b1) begin
            errors++;
            $display("FAIL midrun_before_reset: got pwm=%b irq=%b required pwm=%b irq=1",
                     coe_pwm_out, ins_irq0_irq, exp);
        end
        #2 rsi_rst_n = 1'b0;
        #1;
        checks++;
        if (coe_pwm_out !== 4'h0 || ins_irq0_irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got pwm=%b irq=%b required 0/0", coe_pwm_out, ins_irq0_irq);
        end
        @(negedge csi_clk);
        rsi_rst_n = 1'b1;
        bus_read(0, d);
        checks++;
        if (d !== 32'd500000) begin
            errors++;
            $display("FAIL post_reset_period: got %0d required 500000", d);
        end
        bus_read(5, d);
        checks++;
        if (d !== 32'd250000) begin
            errors++;
            $display("FAIL post_reset_duty0: got %0d required 250000", d);
        end
        repeat (3) idle();
        checks++;
        if (coe_pwm_out !== 4'h0 || ins_irq0_irq !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got pwm=%b irq=%b required 0/0", coe_pwm_out, ins_irq0_irq);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        @(negedge csi_clk);
        test_reset();
        test_basic_pwm();
        test_random_patterns();
        test_duty_update();
        test_irq();
        test_byteenable();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi_avalon.md
PWM_MULTI_AVALON -- requirements
Module: pwm_multi_avalon

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, channel count, legal 1..16.
REQ-002 SHALL have parameter CNT_W, default 32, counter/period/duty width, legal 8..32.
REQ-003 SHALL have parameter PERIOD_RST, default 500000, reset period value.
REQ-004 SHALL have parameter DUTY_RST, default 250000, reset duty value for every channel.
REQ-005 SHALL have localparam ADDR_W = ceil(log2(5+NUM_CH)).
REQ-006 SHALL have csi_clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have rsi_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have avs_s0_chip_select, avs_s0_read and avs_s0_write, each input, 1, Avalon-MM slave strobes.
REQ-009 SHALL have avs_s0_address, input, ADDR_W, word address.
REQ-010 SHALL have avs_s0_byteenable (input, 4), avs_s0_writedata (input, 32) and avs_s0_readdata (output, 32).
REQ-011 SHALL have coe_pwm_out, output, NUM_CH, registered PWM outputs.
REQ-012 SHALL have ins_irq0_irq, output, 1, period-end interrupt.

Function
REQ-013 SHALL use this map: 0 PERIOD, 1 CTRL (bit0 run, bit1 irq_en), 2 CH_EN[NUM_CH-1:0], 3 INVERT[NUM_CH-1:0], 4 STATUS (bit0 period_end, write-1-to-clear), 5+i DUTY[i].
REQ-014 SHALL accept writes only when chip_select & write, updating only the bytes flagged in byteenable.
REQ-015 SHALL ignore written bits above CNT_W (PERIOD/DUTY) or above NUM_CH (mask registers).
REQ-016 SHALL register reads with 1-cycle latency, returning zero-extended 32-bit data regardless of byteenable.
REQ-017 SHALL return 0 on reads of unmapped addresses and ignore writes to them.
REQ-018 SHALL hold PERIOD and DUTY as shadow registers plus active copies; reads return shadow values.
REQ-019 SHALL, while run=1 and period_active>0, count 0..period_active-1 and wrap to 0.
REQ-020 SHALL hold the counter at 0 while run=0 or period_active=0.
REQ-021 SHALL copy shadow to active on the wrap cycle (count==period_active-1), or every cycle while run=0.
REQ-022 SHALL, when a write lands on the wrap cycle, copy the pre-write shadow value to active; the new value applies at the next wrap.
REQ-023 SHALL compute raw[i] = run & CH_EN[i] & (count < duty_active[i]) and register coe_pwm_out[i] = raw[i] XOR INVERT[i], one cycle after count.
REQ-024 SHALL drive output low for duty 0 and high for the whole period when duty >= period (before inversion).
REQ-025 SHALL have a disabled channel (or run=0) drive its INVERT level.
REQ-026 SHALL set STATUS.period_end on each wrap cycle.
REQ-027 SHALL let a set on the wrap cycle win over a simultaneous W1C.
REQ-028 SHALL drive ins_irq0_irq = period_end & irq_en, registered.
REQ-029 SHALL restart the counter at 0 on a run 0->1 transition.

Reset
REQ-030 SHALL, on rsi_rst_n low, immediately set period shadow/active = PERIOD_RST and all duty shadow/active = DUTY_RST.
REQ-031 SHALL, on rsi_rst_n low, immediately clear CTRL, CH_EN, INVERT, STATUS, counter, avs_s0_readdata, coe_pwm_out and ins_irq0_irq to 0.
REQ-032 SHALL, on reset asserted mid-period, force outputs low within the reset assertion with no pending update surviving.

Structure
REQ-033 SHALL place register address constants and CTRL/STATUS bit indices in shared include pwm_regs_pkg.
REQ-034 SHALL instantiate sub-module pwm_channel NUM_CH times, each holding the duty shadow/active pair, comparator and output flop.
REQ-035 SHALL contain the counter, bus decode, shared registers and IRQ in the top level.

Verification
REQ-036 Reset then read addr 0 and addr 5 -> 500000 and 250000; coe_pwm_out = 0.
REQ-037 PERIOD=10, DUTY0=3, CH_EN=1, run=1 -> out[0] high 3 cycles, low 7, repeating.
REQ-038 DUTY0 written 3->8 mid-period -> current period keeps 3 high; next period 8 high; no glitch.
REQ-039 DUTY1=0 / DUTY2=12 with PERIOD=10, INVERT=0b0100 -> out[1] constant 0; out[2] constant 0 (inverted always-high).
REQ-040 irq_en=1, PERIOD=4 -> irq after first wrap; W1C write of STATUS on a wrap cycle leaves the flag set.
REQ-041 Byteenable=0b0010 write of 0xAABBCCDD to PERIOD -> PERIOD byte1 = 0xCC, other bytes unchanged; reset asserted mid-run clears outputs immediately.
